// File: rtl/decode_stage.sv
// Decode stage: classifies the fetched instruction, checks register hazards,
// reads operands and fills the ID/EX pipeline register.
module decode_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_valid,
    input  logic [15:0] if_instr,
    output logic        if_ready,
    output logic [3:0]  rf_src1,
    output logic [3:0]  rf_src2,
    input  logic [15:0] rf_val1,
    input  logic [15:0] rf_val2,
    input  logic        rf_inuse1,
    input  logic        rf_inuse2,
    input  logic        rf_dest_inuse,
    output logic [3:0]  rf_next_dest,
    output logic        rf_dest_we,
    input  logic        ex_ready,
    input  logic        flush,
    output logic        ex_valid,
    output logic [3:0]  ex_op,
    output logic [3:0]  ex_dest,
    output logic [15:0] ex_a,
    output logic [15:0] ex_b,
    output logic        halted,
    output logic [15:0] stall_cnt
);

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_STALL = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LI   = 4'h8;
    localparam logic [3:0] OP_HALT = 4'hF;

    state_t      state_q, state_d;
    logic        ex_valid_q, ex_valid_d;
    logic [3:0]  ex_op_q, ex_op_d;
    logic [3:0]  ex_dest_q, ex_dest_d;
    logic [15:0] ex_a_q, ex_a_d;
    logic [15:0] ex_b_q, ex_b_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;

    logic [3:0] op;
    logic       is_li;
    logic       is_halt;
    logic       is_alu;
    logic       hazard;
    logic       slot_free;
    logic       issue;

    assign op      = if_instr[15:12];
    assign is_li   = (op == OP_LI);
    assign is_halt = (op == OP_HALT);
    assign is_alu  = (op != OP_NOP) && !is_li && !is_halt;

    assign rf_src1      = if_instr[7:4];
    assign rf_src2      = if_instr[3:0];
    assign rf_next_dest = if_instr[11:8];

    // Hazard detection, issue qualification and register-file write marking
    always_comb begin
        hazard = if_valid &&
                 ((is_alu && (rf_inuse1 || rf_inuse2)) ||
                  ((is_alu || is_li) && rf_dest_inuse));
        slot_free  = !ex_valid_q || ex_ready;
        // rst is asynchronous, so block issue combinationally while it is high
        issue      = !rst && (state_q != S_HALT) && if_valid &&
                     !hazard && slot_free && !flush;
        if_ready   = issue;
        rf_dest_we = issue && (is_alu || is_li);
    end

    // Next-state logic: flush only releases a stall, otherwise state holds
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_RUN: begin
                if (!flush) begin
                    if (issue && is_halt) begin
                        state_d = S_HALT;
                    end else if (hazard) begin
                        state_d = S_STALL;
                    end
                end
            end
            S_STALL: begin
                if (flush) begin
                    state_d = S_RUN;
                end else if (issue && is_halt) begin
                    state_d = S_HALT;
                end else if (issue || !if_valid) begin
                    state_d = S_RUN;
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_RUN;
            end
        endcase
    end

    // ID/EX pipeline register contents and saturating stall counter
    always_comb begin
        ex_valid_d  = ex_valid_q;
        ex_op_d     = ex_op_q;
        ex_dest_d   = ex_dest_q;
        ex_a_d      = ex_a_q;
        ex_b_d      = ex_b_q;
        stall_cnt_d = stall_cnt_q;
        if (flush) begin
            ex_valid_d = 1'b0;
        end else if (issue) begin
            ex_valid_d = 1'b1;
            ex_op_d    = op;
            ex_dest_d  = if_instr[11:8];
            unique case (1'b1)
                is_alu: begin
                    ex_a_d = rf_val1;
                    ex_b_d = rf_val2;
                end
                is_li: begin
                    ex_a_d = {8'h00, if_instr[7:0]};
                    ex_b_d = 16'h0000;
                end
                default: begin
                    ex_a_d = 16'h0000;
                    ex_b_d = 16'h0000;
                end
            endcase
        end else if (ex_ready) begin
            ex_valid_d = 1'b0;
        end
        if (hazard && (state_q != S_HALT) && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    // State and pipeline registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_RUN;
            ex_valid_q  <= 1'b0;
            ex_op_q     <= 4'h0;
            ex_dest_q   <= 4'h0;
            ex_a_q      <= 16'h0000;
            ex_b_q      <= 16'h0000;
            stall_cnt_q <= 16'h0000;
        end else begin
            state_q     <= state_d;
            ex_valid_q  <= ex_valid_d;
            ex_op_q     <= ex_op_d;
            ex_dest_q   <= ex_dest_d;
            ex_a_q      <= ex_a_d;
            ex_b_q      <= ex_b_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign ex_valid  = ex_valid_q;
    assign ex_op     = ex_op_q;
    assign ex_dest   = ex_dest_q;
    assign ex_a      = ex_a_q;
    assign ex_b      = ex_b_q;
    assign halted    = (state_q == S_HALT);
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed scenarios plus randomized traffic,
// all checked against a cycle-level behavioural model.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_valid = 1'b0;
    logic [15:0] if_instr = 16'h0000;
    logic        if_ready;
    logic [3:0]  rf_src1, rf_src2;
    logic [15:0] rf_val1 = 16'h0000;
    logic [15:0] rf_val2 = 16'h0000;
    logic        rf_inuse1 = 1'b0;
    logic        rf_inuse2 = 1'b0;
    logic        rf_dest_inuse = 1'b0;
    logic [3:0]  rf_next_dest;
    logic        rf_dest_we;
    logic        ex_ready = 1'b1;
    logic        flush = 1'b0;
    logic        ex_valid;
    logic [3:0]  ex_op, ex_dest;
    logic [15:0] ex_a, ex_b;
    logic        halted;
    logic [15:0] stall_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state
    bit          m_halted;
    bit          m_ev;
    logic [3:0]  m_op, m_dest;
    logic [15:0] m_a, m_b;
    int          m_cnt;

    logic obs_ready, obs_we;

    decode_stage dut (
        .clk(clk), .rst(rst),
        .if_valid(if_valid), .if_instr(if_instr), .if_ready(if_ready),
        .rf_src1(rf_src1), .rf_src2(rf_src2),
        .rf_val1(rf_val1), .rf_val2(rf_val2),
        .rf_inuse1(rf_inuse1), .rf_inuse2(rf_inuse2),
        .rf_dest_inuse(rf_dest_inuse),
        .rf_next_dest(rf_next_dest), .rf_dest_we(rf_dest_we),
        .ex_ready(ex_ready), .flush(flush),
        .ex_valid(ex_valid), .ex_op(ex_op), .ex_dest(ex_dest),
        .ex_a(ex_a), .ex_b(ex_b),
        .halted(halted), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_halted = 0;
        m_ev = 0;
        m_op = 4'h0;
        m_dest = 4'h0;
        m_a = 16'h0;
        m_b = 16'h0;
        m_cnt = 0;
    endtask

    task automatic chk_regs(input string tag);
        chk({tag, ".ex_valid"}, {15'd0, ex_valid}, {15'd0, m_ev});
        chk({tag, ".ex_op"}, {12'd0, ex_op}, {12'd0, m_op});
        chk({tag, ".ex_dest"}, {12'd0, ex_dest}, {12'd0, m_dest});
        chk({tag, ".ex_a"}, ex_a, m_a);
        chk({tag, ".ex_b"}, ex_b, m_b);
        chk({tag, ".halted"}, {15'd0, halted}, {15'd0, m_halted});
        chk({tag, ".stall_cnt"}, stall_cnt, m_cnt[15:0]);
    endtask

    // One clock: settle inputs, check combinational outputs, clock, check regs
    task automatic cycle(input string tag);
        logic [3:0] op;
        bit has_src, has_dst, haz, iss;
        #1;
        op = if_instr[15:12];
        has_src = (op != 4'h0) && (op != 4'h8) && (op != 4'hF);
        has_dst = has_src || (op == 4'h8);
        haz = if_valid && ((has_src && (rf_inuse1 || rf_inuse2)) ||
                           (has_dst && rf_dest_inuse));
        iss = !m_halted && if_valid && !haz && (!m_ev || ex_ready) && !flush;
        obs_ready = if_ready;
        obs_we = rf_dest_we;
        chk({tag, ".if_ready"}, {15'd0, if_ready}, {15'd0, iss});
        chk({tag, ".rf_dest_we"}, {15'd0, rf_dest_we}, {15'd0, iss && has_dst});
        chk({tag, ".rf_src1"}, {12'd0, rf_src1}, {12'd0, if_instr[7:4]});
        chk({tag, ".rf_src2"}, {12'd0, rf_src2}, {12'd0, if_instr[3:0]});
        chk({tag, ".rf_next_dest"}, {12'd0, rf_next_dest},
            {12'd0, if_instr[11:8]});
        if (haz && !m_halted && m_cnt < 65535) m_cnt++;
        if (flush) begin
            m_ev = 0;
        end else if (iss) begin
            m_ev = 1;
            m_op = op;
            m_dest = if_instr[11:8];
            if (has_src) begin
                m_a = rf_val1;
                m_b = rf_val2;
            end else if (op == 4'h8) begin
                m_a = {8'h00, if_instr[7:0]};
                m_b = 16'h0;
            end else begin
                m_a = 16'h0;
                m_b = 16'h0;
            end
            if (op == 4'hF) m_halted = 1;
        end else if (ex_ready) begin
            m_ev = 0;
        end
        @(posedge clk);
        #1;
        chk_regs(tag);
    endtask

    // Asynchronous reset pulse, released on the falling edge
    task automatic do_reset(input string tag);
        rst = 1'b1;
        #1;
        model_reset();
        chk_regs(tag);
        chk({tag, ".rst_ready"}, {15'd0, if_ready}, 16'd0);
        chk({tag, ".rst_we"}, {15'd0, rf_dest_we}, 16'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic idle_inputs();
        if_valid = 0;
        if_instr = 16'h0000;
        rf_inuse1 = 0;
        rf_inuse2 = 0;
        rf_dest_inuse = 0;
        ex_ready = 1;
        flush = 0;
        rf_val1 = 16'h0;
        rf_val2 = 16'h0;
    endtask

    initial begin
        model_reset();
        idle_inputs();
        @(posedge clk);
        #1;
        do_reset("por");

        // basic ALU issue
        if_valid = 1;
        if_instr = 16'h1312;
        rf_val1 = 16'h0005;
        rf_val2 = 16'h0007;
        cycle("alu");
        chk("alu.rdy", {15'd0, obs_ready}, 16'd1);
        chk("alu.we", {15'd0, obs_we}, 16'd1);
        chk("alu.a", ex_a, 16'h0005);
        chk("alu.b", ex_b, 16'h0007);
        chk("alu.dest", {12'd0, ex_dest}, 16'd3);

        // source hazard for three cycles
        idle_inputs();
        do_reset("r2");
        if_valid = 1;
        if_instr = 16'h1312;
        rf_val1 = 16'h0005;
        rf_val2 = 16'h0007;
        rf_inuse1 = 1;
        for (int i = 0; i < 3; i++) begin
            cycle("haz");
            chk("haz.rdy", {15'd0, obs_ready}, 16'd0);
        end
        chk("haz.cnt", stall_cnt, 16'd3);
        rf_inuse1 = 0;
        cycle("haz_rel");
        chk("haz_rel.rdy", {15'd0, obs_ready}, 16'd1);

        // back-pressure from execute
        ex_ready = 0;
        if_instr = 16'h2534;
        rf_val1 = 16'h1111;
        rf_val2 = 16'h2222;
        cycle("bp");
        chk("bp.rdy", {15'd0, obs_ready}, 16'd0);
        chk("bp.hold", ex_a, 16'h0005);
        ex_ready = 1;
        cycle("bp_go");
        chk("bp_go.rdy", {15'd0, obs_ready}, 16'd1);
        chk("bp_go.a", ex_a, 16'h1111);

        // load-immediate then halt
        if_instr = 16'h84A5;
        rf_val1 = 16'hBEEF;
        cycle("li");
        chk("li.a", ex_a, 16'h00A5);
        chk("li.b", ex_b, 16'h0000);
        chk("li.dest", {12'd0, ex_dest}, 16'd4);
        if_instr = 16'hF000;
        cycle("halt");
        chk("halt.flag", {15'd0, halted}, 16'd1);
        if_instr = 16'h1312;
        for (int i = 0; i < 10; i++) begin
            cycle("halted");
            chk("halted.rdy", {15'd0, obs_ready}, 16'd0);
        end
        do_reset("r_halt");
        chk("r_halt.flag", {15'd0, halted}, 16'd0);

        // flush against an issuable instruction with a held pipeline reg
        if_valid = 1;
        if_instr = 16'h1312;
        ex_ready = 0;
        cycle("pre_fl");
        flush = 1;
        cycle("flush");
        chk("flush.rdy", {15'd0, obs_ready}, 16'd0);
        chk("flush.we", {15'd0, obs_we}, 16'd0);
        chk("flush.ev", {15'd0, ex_valid}, 16'd0);
        flush = 0;
        ex_ready = 1;

        // reset in the middle of a stall
        rf_dest_inuse = 1;
        for (int i = 0; i < 5; i++) cycle("stall5");
        chk("stall5.cnt", stall_cnt, 16'd5);
        #2;
        do_reset("r_stall");
        chk("r_stall.cnt", stall_cnt, 16'd0);
        rf_dest_inuse = 0;
        if_instr = 16'h2721;
        rf_val1 = 16'h0042;
        rf_val2 = 16'h0099;
        cycle("post_rst");
        chk("post_rst.rdy", {15'd0, obs_ready}, 16'd1);
        chk("post_rst.a", ex_a, 16'h0042);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic [3:0] op;
            if ($urandom_range(0, 199) == 0) do_reset("rnd_rst");
            op = 4'($urandom_range(0, 15));
            if (op == 4'hF && $urandom_range(0, 7) != 0) op = 4'h1;
            if_valid = ($urandom_range(0, 3) != 0);
            if_instr = {op, 12'($urandom)};
            rf_val1 = 16'($urandom);
            rf_val2 = 16'($urandom);
            rf_inuse1 = ($urandom_range(0, 3) == 0);
            rf_inuse2 = ($urandom_range(0, 3) == 0);
            rf_dest_inuse = ($urandom_range(0, 4) == 0);
            ex_ready = ($urandom_range(0, 2) != 0);
            flush = ($urandom_range(0, 9) == 0);
            cycle("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
